bk_serial_add_ctrl: RTL and testbench

- Sequencer that adds two WIDTH-bit operands using a single 4-bit Brent-Kung adder slice, one nibble per clock, least significant nibble first.
- A carry register links each nibble to the next.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area in wide-add paths.

---
 rtl/bk_serial_add_ctrl_if.sv | 28 ++
 rtl/bk_serial_add_ctrl.sv | 152 +++++++++++++++
 tb/tb_bk_serial_add_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The producer drives in_valid/a/b/cin; the consumer drives out_ready.
// The adder sits on the slave side of both handshakes.
interface bk_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Adder side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

  // Producer/consumer side
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/bk_serial_add_ctrl.sv
// Nibble-serial adder: one 4-bit Brent-Kung slice reused across NIB cycles,
// LS nibble first, with a carry register chaining the nibbles.
// Handshake: accept in IDLE, NIB cycles in RUN, hold the result in DONE
// until the consumer takes it.

// Purely combinational 4-bit Brent-Kung adder with carry-in folded into
// the prefix tree so co is the true carry of a + b + ci.
module bk_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic       g10, p10, g32, p32;
  logic       g20, p20, g30, p30;
  logic [4:0] c;

  // Prefix tree: pair level, then the 4-wide group, then the fill-in node for bit 2
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g10  | (p10  & ci);
    c[3] = g20  | (p20  & ci);
    c[4] = g30  | (p30  & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

module bk_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bk_serial_add_ctrl_if.slave   bus,
  output logic                  busy
);
  localparam int NIB  = WIDTH / 4;
  // Counter only needs to reach NIB-1; keep at least one bit for NIB == 1
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [3:0]       s4;
  logic             s_co;

  // The single shared slice always looks at the bottom nibble of the
  // operand shift registers, so no wide mux is needed on the inputs.
  bk_slice4 u_slice (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (carry_q),
    .s  (s4),
    .co (s_co)
  );

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = s_co;
        // Constant-index nibble write keeps the sum register a plain
        // per-nibble enable rather than a variable shifter.
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDXW'(i)) sum_d[4*i +: 4] = s4;
        end
        if (idx_q == IDX_LAST) begin
          cout_d  = s_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any add in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake flags decode straight from the state register
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_bk_serial_add_ctrl.sv
// Bench for the nibble-serial adder: a 16-bit and a 4-bit instance side by side.
// The reference model tracks each transaction as a number (a+b+cin) plus the
// accept time; a per-cycle compare checks handshakes and results against it.
module tb_bk_serial_add_ctrl;
  logic clk;
  logic rst_n;
  logic busy16, busy4;

  bk_serial_add_ctrl_if #(.WIDTH(16)) if16 ();
  bk_serial_add_ctrl_if #(.WIDTH(4))  if4 ();

  bk_serial_add_ctrl #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave), .busy(busy16));
  bk_serial_add_ctrl #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave),  .busy(busy4));

  // Stimulus per instance: index 0 = WIDTH 16, index 1 = WIDTH 4
  logic        iv[2];
  logic [15:0] av[2];
  logic [15:0] bv[2];
  logic        ci[2];
  logic        ordy[2];

  assign if16.in_valid  = iv[0];
  assign if16.a         = av[0];
  assign if16.b         = bv[0];
  assign if16.cin       = ci[0];
  assign if16.out_ready = ordy[0];
  assign if4.in_valid   = iv[1];
  assign if4.a          = av[1][3:0];
  assign if4.b          = bv[1][3:0];
  assign if4.cin        = ci[1];
  assign if4.out_ready  = ordy[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  int          n_run, n_fail;
  int          cyc;
  bit          have_op[2];
  int          acc_cyc[2];
  logic [16:0] res[2];
  logic [16:0] last[2];
  int          nib[2];
  int          acc_dut[2], hs_dut[2], acc_mdl[2], hs_mdl[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic string pfx(input int d);
    return (d == 0) ? "w16" : "w4";
  endfunction

  // Result is valid once NIB edges have passed since the accept edge
  function automatic bit mov(input int d);
    return have_op[d] && (cyc >= acc_cyc[d] + nib[d]);
  endfunction

  function automatic logic [16:0] model_res(input int d, input logic [15:0] a, input logic [15:0] b, input logic c);
    if (d == 0) return {1'b0, a} + {1'b0, b} + {16'b0, c};
    return {12'b0, {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, c}};
  endfunction

  task automatic obs(input int d, output logic ir, output logic ov, output logic bz, output logic [16:0] r);
    if (d == 0) begin
      ir = if16.in_ready; ov = if16.out_valid; bz = busy16; r = {if16.cout, if16.sum};
    end else begin
      ir = if4.in_ready; ov = if4.out_valid; bz = busy4; r = {12'b0, if4.cout, if4.sum};
    end
  endtask

  // One clock: predict handshakes, advance model at the edge, compare at negedge
  task automatic step();
    bit          acc[2];
    bit          hs[2];
    logic        ir, ov, bz;
    logic [16:0] r;
    for (int d = 0; d < 2; d++) begin
      acc[d] = iv[d] && !have_op[d];
      hs[d]  = ordy[d] && mov(d);
      obs(d, ir, ov, bz, r);
      if (iv[d] && ir) acc_dut[d]++;
      if (ov && ordy[d]) hs_dut[d]++;
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (hs[d]) begin
        have_op[d] = 0;
        last[d]    = res[d];
        hs_mdl[d]++;
      end
      if (acc[d]) begin
        have_op[d] = 1;
        acc_cyc[d] = cyc;
        res[d]     = model_res(d, av[d], bv[d], ci[d]);
        acc_mdl[d]++;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      obs(d, ir, ov, bz, r);
      chk({pfx(d), "_in_ready"},  {31'b0, ir}, {31'b0, !have_op[d]});
      chk({pfx(d), "_busy"},      {31'b0, bz}, {31'b0, have_op[d]});
      chk({pfx(d), "_out_valid"}, {31'b0, ov}, {31'b0, mov(d)});
      if (mov(d))           chk({pfx(d), "_result"},      {15'b0, r}, {15'b0, res[d]});
      else if (!have_op[d]) chk({pfx(d), "_held_result"}, {15'b0, r}, {15'b0, last[d]});
    end
  endtask

  // Directed add with out_ready high: literal latency and value checks
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] exp);
    logic        ir, ov, bz;
    logic [16:0] r;
    av[d] = a; bv[d] = b; ci[d] = c; iv[d] = 1'b1; ordy[d] = 1'b1;
    step();
    iv[d] = 1'b0; av[d] = ~a; bv[d] = 16'h5A5A; ci[d] = ~c;
    repeat (nib[d] - 1) step();
    obs(d, ir, ov, bz, r);
    chk({pfx(d), "_lit_pre_valid"}, {31'b0, ov}, 32'd0);
    step();
    obs(d, ir, ov, bz, r);
    chk({pfx(d), "_lit_valid"}, {31'b0, ov}, 32'd1);
    chk({pfx(d), "_lit_sum"}, {15'b0, r}, {15'b0, exp});
    step();
    obs(d, ir, ov, bz, r);
    chk({pfx(d), "_lit_idle_valid"}, {31'b0, ov}, 32'd0);
    chk({pfx(d), "_lit_idle_ready"}, {31'b0, ir}, 32'd1);
  endtask

  task automatic chk_reset_lits();
    logic        ir, ov, bz;
    logic [16:0] r;
    for (int d = 0; d < 2; d++) begin
      obs(d, ir, ov, bz, r);
      chk({pfx(d), "_rst_in_ready"},  {31'b0, ir}, 32'd1);
      chk({pfx(d), "_rst_out_valid"}, {31'b0, ov}, 32'd0);
      chk({pfx(d), "_rst_busy"},      {31'b0, bz}, 32'd0);
      chk({pfx(d), "_rst_sum_cout"},  {15'b0, r},  32'd0);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      have_op[d] = 0;
      last[d]    = '0;
      res[d]     = '0;
      acc_cyc[d] = 0;
    end
  endtask

  initial begin
    logic        ir, ov, bz;
    logic [16:0] r;
    int          k;
    n_run = 0; n_fail = 0; cyc = 0;
    nib[0] = 4; nib[1] = 1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; av[d] = '0; bv[d] = '0; ci[d] = 1'b0; ordy[d] = 1'b1;
      acc_dut[d] = 0; hs_dut[d] = 0; acc_mdl[d] = 0; hs_mdl[d] = 0;
    end
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_lits();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic adds and full-width carry ripple
    run_op(0, 16'h1234, 16'h4321, 1'b0, 17'h05555);
    run_op(0, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    run_op(1, 16'h000F, 16'h0000, 1'b1, 17'h00010);
    run_op(1, 16'h0007, 16'h0008, 1'b0, 17'h0000F);
    run_op(1, 16'h000F, 16'h000F, 1'b1, 17'h0001F);

    // Backpressure: stall in DONE with new operands already offered
    av[0] = 16'h0F0F; bv[0] = 16'h0101; ci[0] = 1'b0; iv[0] = 1'b1; ordy[0] = 1'b0;
    step();
    iv[0] = 1'b0;
    repeat (4) step();
    av[0] = 16'h1111; bv[0] = 16'h2222; ci[0] = 1'b1; iv[0] = 1'b1;
    repeat (10) begin
      step();
      obs(0, ir, ov, bz, r);
      chk("w16_stall_valid", {31'b0, ov}, 32'd1);
      chk("w16_stall_ready", {31'b0, ir}, 32'd0);
      chk("w16_stall_sum",   {15'b0, r},  32'h01010);
    end
    ordy[0] = 1'b1;
    step();
    obs(0, ir, ov, bz, r);
    chk("w16_after_hs_valid", {31'b0, ov}, 32'd0);
    step();
    iv[0] = 1'b0;
    obs(0, ir, ov, bz, r);
    chk("w16_reaccept_busy", {31'b0, bz}, 32'd1);
    repeat (4) step();
    obs(0, ir, ov, bz, r);
    chk("w16_second_sum", {15'b0, r}, 32'h03334);
    step();

    // Asynchronous reset while RUN sits at nibble index 2
    av[0] = 16'h8888; bv[0] = 16'h8888; ci[0] = 1'b0; iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk_reset_lits();
    model_clear();
    #2;
    rst_n = 1'b1;
    repeat (6) step();
    run_op(0, 16'h0001, 16'h0001, 1'b0, 17'h00002);

    // Random regression with random stalls and in_valid noise while busy
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 1000; n++) begin
        av[d] = 16'($urandom); bv[d] = 16'($urandom); ci[d] = 1'($urandom_range(0, 1));
        iv[d] = 1'b1;
        k = 0;
        while (!have_op[d] && k < 50) begin
          ordy[d] = 1'($urandom_range(0, 1));
          step();
          k++;
        end
        if (!have_op[d]) chk({pfx(d), "_accept_timeout"}, 32'd0, 32'd1);
        iv[d] = 1'b0;
        k = 0;
        while (have_op[d] && k < 100) begin
          iv[d] = 1'($urandom_range(0, 1));
          av[d] = 16'($urandom); bv[d] = 16'($urandom);
          ordy[d] = ($urandom_range(0, 3) != 0);
          step();
          k++;
        end
        iv[d] = 1'b0;
        if (have_op[d]) chk({pfx(d), "_drain_timeout"}, 32'd0, 32'd1);
      end
      ordy[d] = 1'b1;
    end
    repeat (2) step();

    for (int d = 0; d < 2; d++) begin
      chk({pfx(d), "_accept_count"}, acc_dut[d], acc_mdl[d]);
      chk({pfx(d), "_handshake_count"}, hs_dut[d], hs_mdl[d]);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
